imu_burst_scheduler: RTL and testbench

- Sequences one burst of IMU register reads per IMU data-ready event.
- Each burst drives the byte-wide serial bus master (SPI/I2C engine) with a start/done handshake and pairs bytes into 16-bit big-endian words.
- Words go out on a valid/ready stream to the message framer, one word per handshake.
- Sits between the IMU interrupt pin, the bus master and the downstream message path; provides overrun, bus-error and timeout detection.

---
 rtl/imu_burst_scheduler.sv | 274 +++++++++++++++++++++++++++
 tb/tb_imu_burst_scheduler.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_burst_scheduler.sv
// ---------------------------------------------------------------------------
// imu_burst_scheduler
//
// Turns each IMU data-ready event into one burst of single-byte register
// reads on the serial bus master.  Bytes are paired into big-endian 16-bit
// words and handed downstream on a valid/ready stream, one word per
// handshake.  Overrun, bus-error and WAIT-timeout conditions are flagged.
//
// Parameters
//   N_WORDS      16-bit words per burst, 1..8
//   BASE_ADDR    register address of the first (high) byte
//   TIMEOUT_CYC  clk cycles from bus_start to the timeout abort, >= 2
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   en           scheduler enable (level)
//   data_ready   IMU data-ready pin, asynchronous to clk
//   bus_start    one-cycle read request to the bus master
//   bus_addr     register address, stable from bus_start until bus_done
//   bus_done     one-cycle read-complete pulse, bus_rdata valid with it
//   bus_err      NACK / bus fault, qualified by bus_done
//   bus_rdata    read byte
//   out_valid    word available downstream
//   out_ready    downstream accepts the word
//   out_data     {high byte, low byte}
//   out_idx      word index within the burst
//   frame_done   one-cycle pulse after the last word of a burst is accepted
//   overrun      sticky: data-ready edge seen while a burst was active
//   err          sticky: last aborted burst ended on bus_err or timeout
//   err_code     00 none, 01 bus_err, 10 timeout
//
// State table
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for a synchronized data-ready edge with en=1
//   S_ISSUE | bus_start pulse for the byte at bus_addr
//   S_WAIT  | waiting for bus_done; timeout counter running
//   S_EMIT  | word presented on out_valid until accepted or en drops
// ---------------------------------------------------------------------------
module imu_burst_scheduler #(
  parameter int          N_WORDS     = 6,
  parameter logic [7:0]  BASE_ADDR   = 8'h3B,
  parameter int          TIMEOUT_CYC = 125000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        data_ready,
  output logic        bus_start,
  output logic [7:0]  bus_addr,
  input  logic        bus_done,
  input  logic        bus_err,
  input  logic [7:0]  bus_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_idx,
  output logic        frame_done,
  output logic        overrun,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // The abort is taken on the edge where the counter would step onto
  // TIMEOUT_CYC-1.  With the counter at 0 in the first WAIT cycle, err then
  // becomes visible exactly TIMEOUT_CYC cycles after the bus_start cycle.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 2);
  localparam logic [2:0]    LAST_WORD = 3'(N_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t state, state_d;

  logic          sync1, sync2, sync3;
  logic          dr_edge;
  logic [TW-1:0] tmo_cnt;
  logic          byte_sel;
  logic [2:0]    word_cnt;
  logic [7:0]    data_hi, data_lo;

  logic start_burst;
  logic take_byte;
  logic fail_bus;
  logic fail_tmo;
  logic accept_word;
  logic accept_last;

  // -------------------------------------------------------------------------
  // data_ready synchronizer and rising-edge detect
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= data_ready;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign dr_edge = sync2 & ~sync3;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state;
    start_burst = 1'b0;
    take_byte   = 1'b0;
    fail_bus    = 1'b0;
    fail_tmo    = 1'b0;
    accept_word = 1'b0;
    accept_last = 1'b0;
    bus_start   = 1'b0;
    out_valid   = 1'b0;

    case (state)
      S_IDLE: begin
        if (dr_edge && en) begin
          start_burst = 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        bus_start = 1'b1;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        if (bus_done) begin
          if (bus_err) begin
            fail_bus = 1'b1;
            state_d  = S_IDLE;
          end else if (!en) begin
            // Read completed after en dropped: discard it quietly.
            state_d = S_IDLE;
          end else begin
            take_byte = 1'b1;
            state_d   = byte_sel ? S_EMIT : S_ISSUE;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          fail_tmo = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_EMIT: begin
        // Gating with en keeps a handshake from completing on the cycle the
        // burst is being abandoned.
        out_valid = en;
        if (!en) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          accept_word = 1'b1;
          if (word_cnt == LAST_WORD) begin
            accept_last = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // WAIT timeout counter: held at 0 outside WAIT so every entry starts clean
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state != S_WAIT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Address, byte pairing and word counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_addr <= BASE_ADDR;
      byte_sel <= 1'b0;
      data_hi  <= 8'h00;
      data_lo  <= 8'h00;
      word_cnt <= 3'd0;
    end else begin
      if (start_burst) begin
        bus_addr <= BASE_ADDR;
        byte_sel <= 1'b0;
        word_cnt <= 3'd0;
      end

      if (take_byte) begin
        if (byte_sel) begin
          data_lo <= bus_rdata;
        end else begin
          data_hi <= bus_rdata;
        end
        bus_addr <= bus_addr + 8'd1;
        byte_sel <= ~byte_sel;
      end

      if (accept_word && !accept_last) begin
        word_cnt <= word_cnt + 3'd1;
      end
    end
  end

  assign out_data = {data_hi, data_lo};
  assign out_idx  = word_cnt;

  // -------------------------------------------------------------------------
  // Status flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      frame_done <= accept_last;

      if (start_burst) begin
        overrun  <= 1'b0;
        err      <= 1'b0;
        err_code <= 2'b00;
      end

      // An edge outside IDLE is dropped; only the fact is recorded.
      if (dr_edge && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end

      if (fail_bus) begin
        err      <= 1'b1;
        err_code <= 2'b01;
      end

      if (fail_tmo) begin
        err      <= 1'b1;
        err_code <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_imu_burst_scheduler.sv
module tb_imu_burst_scheduler;

  localparam int         NW    = 6;
  localparam int         T_CYC = 100;
  localparam logic [7:0] BASE  = 8'h3B;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        data_ready;
  logic        bus_start;
  logic [7:0]  bus_addr;
  logic        bus_done;
  logic        bus_err;
  logic [7:0]  bus_rdata;
  logic        out_valid;
  wire         out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        frame_done;
  logic        overrun;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  imu_burst_scheduler #(
    .N_WORDS    (NW),
    .BASE_ADDR  (BASE),
    .TIMEOUT_CYC(T_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data_ready(data_ready),
    .bus_start (bus_start),
    .bus_addr  (bus_addr),
    .bus_done  (bus_done),
    .bus_err   (bus_err),
    .bus_rdata (bus_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .frame_done(frame_done),
    .overrun   (overrun),
    .err       (err),
    .err_code  (err_code)
  );

  // bench configuration, written only by the main sequence
  int         bus_lat    = 10;
  bit         bus_mute   = 1'b0;
  bit         err_en     = 1'b0;
  logic [7:0] err_addr   = 8'h00;
  logic [7:0] data_ofs   = 8'h00;
  bit         ready_rand = 1'b0;
  bit         ready_force = 1'b1;
  bit         rnd_bit;

  assign out_ready = ready_rand ? rnd_bit : ready_force;

  typedef struct packed {
    logic [2:0]  i;
    logic [15:0] d;
  } word_t;

  word_t      wlog[$];
  logic [7:0] alog[$];
  int         fd_cnt = 0;

  int checks = 0;
  int errors = 0;

  // Register value returned by the bus model: its 1-based position in the
  // burst's address range, shifted by a per-burst offset.
  function automatic logic [7:0] reg_val(input logic [7:0] a, input logic [7:0] ofs);
    return a - BASE + 8'd1 + ofs;
  endfunction

  // bus master model: latency counted from the bus_start cycle
  initial begin : bus_model
    int         pend;
    logic [7:0] cur;
    pend      = 0;
    cur       = 8'h00;
    bus_done  = 1'b0;
    bus_err   = 1'b0;
    bus_rdata = 8'h00;
    rnd_bit   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_done = 1'b0;
      bus_err  = 1'b0;
      rnd_bit  = 1'($urandom_range(0, 1));
      if (rst !== 1'b1) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus_done  = 1'b1;
            bus_rdata = reg_val(cur, data_ofs);
            bus_err   = err_en && (cur == err_addr);
          end
        end
        if (bus_start === 1'b1) begin
          cur = bus_addr;
          alog.push_back(bus_addr);
          if (!bus_mute) pend = bus_lat;
        end
      end
    end
  end

  // output monitor: inputs change just after posedge, so the negedge view
  // predicts the handshake at the coming edge
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) wlog.push_back('{out_idx, out_data});
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event within bound, expected event", name);
  endtask

  task automatic pulse_dr;
    data_ready = 1'b1;
    tick;
    tick;
    tick;
    data_ready = 1'b0;
    tick;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 1000) begin
      tick;
      k++;
    end
    if (k >= 1000) bound_fail({tag, " wait_valid"});
  endtask

  task automatic wait_done(input string tag, input int fd0);
    int k;
    k = 0;
    while (fd_cnt == fd0 && err !== 1'b1 && k < 4000) begin
      tick;
      k++;
    end
    if (k >= 4000) bound_fail({tag, " wait_done"});
    repeat (3) tick;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " bus_start"},  32'(bus_start),  32'd0);
    chk({tag, " bus_addr"},   32'(bus_addr),   32'(BASE));
    chk({tag, " out_valid"},  32'(out_valid),  32'd0);
    chk({tag, " out_data"},   32'(out_data),   32'd0);
    chk({tag, " out_idx"},    32'(out_idx),    32'd0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, " overrun"},    32'(overrun),    32'd0);
    chk({tag, " err"},        32'(err),        32'd0);
    chk({tag, " err_code"},   32'(err_code),   32'd0);
  endtask

  // Reference model: a burst reads BASE.. upward, one address per byte.
  // A failing read ends the burst; only complete pairs before it are words.
  task automatic check_burst(input string tag, input int w0, input int a0, input int fd0,
                             input bit has_err, input logic [7:0] erra, input logic [7:0] ofs);
    int         reads, words;
    logic [7:0] a;
    logic [15:0] exp_d;
    reads = has_err ? int'(erra - BASE) + 1 : 2 * NW;
    words = has_err ? (reads - 1) / 2 : NW;
    chk({tag, " reads"}, 32'(alog.size() - a0), 32'(reads));
    for (int r = 0; r < reads && a0 + r < alog.size(); r++) begin
      a = BASE + 8'(r);
      chk($sformatf("%s addr%0d", tag, r), 32'(alog[a0 + r]), 32'(a));
    end
    chk({tag, " words"}, 32'(wlog.size() - w0), 32'(words));
    for (int w = 0; w < words && w0 + w < wlog.size(); w++) begin
      a     = BASE + 8'(2 * w);
      exp_d = {reg_val(a, ofs), reg_val(a + 8'd1, ofs)};
      chk($sformatf("%s data%0d", tag, w), 32'(wlog[w0 + w].d), 32'(exp_d));
      chk($sformatf("%s idx%0d", tag, w),  32'(wlog[w0 + w].i), 32'(w));
    end
    chk({tag, " frame_done"}, 32'(fd_cnt - fd0), has_err ? 32'd0 : 32'd1);
    chk({tag, " err"},        32'(err),          has_err ? 32'd1 : 32'd0);
    chk({tag, " err_code"},   32'(err_code),     has_err ? 32'd1 : 32'd0);
  endtask

  task automatic run_burst(input string tag, input bit he, input logic [7:0] ea,
                           input logic [7:0] ofs, output int w0, output int fd0);
    int a0;
    err_en   = he;
    err_addr = ea;
    data_ofs = ofs;
    w0  = wlog.size();
    a0  = alog.size();
    fd0 = fd_cnt;
    pulse_dr;
    wait_done(tag, fd0);
    check_burst(tag, w0, a0, fd0, he, ea, ofs);
  endtask

  typedef struct {
    int         lat;
    bit         has_err;
    logic [7:0] erra;
    logic [7:0] ofs;
    bit         rnd_ready;
    int         exp_words;
    bit         exp_fd;
    logic [1:0] exp_code;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    int w0, a0, fd0, a1, k;
    int bad_v, bad_d, starts;
    bit he;
    logic [7:0] ea;

    vecs[0] = '{10, 1'b0, 8'h00, 8'h00, 1'b0, 6, 1'b1, 2'b00};
    vecs[1] = '{1,  1'b0, 8'h00, 8'h40, 1'b1, 6, 1'b1, 2'b00};
    vecs[2] = '{10, 1'b1, 8'h3F, 8'h00, 1'b0, 2, 1'b0, 2'b01};
    vecs[3] = '{3,  1'b1, 8'h3B, 8'h10, 1'b0, 0, 1'b0, 2'b01};
    vecs[4] = '{5,  1'b1, 8'h3C, 8'h00, 1'b1, 0, 1'b0, 2'b01};
    vecs[5] = '{7,  1'b1, 8'h46, 8'h22, 1'b1, 5, 1'b0, 2'b01};
    vecs[6] = '{2,  1'b0, 8'h00, 8'hF0, 1'b1, 6, 1'b1, 2'b00};

    rst        = 1'b0;
    en         = 1'b1;
    data_ready = 1'b0;
    repeat (3) tick;
    check_reset_vals("reset");
    rst = 1'b1;
    repeat (2) tick;

    // nominal burst with pin-to-bus_start latency
    bus_lat = 10; ready_rand = 1'b0; ready_force = 1'b1;
    err_en = 1'b0; data_ofs = 8'h00;
    w0 = wlog.size(); a0 = alog.size(); fd0 = fd_cnt;
    data_ready = 1'b1;
    tick; chk("lat edge1 bus_start", 32'(bus_start), 32'd0);
    tick; chk("lat edge2 bus_start", 32'(bus_start), 32'd0);
    tick; chk("lat edge3 bus_start", 32'(bus_start), 32'd1);
    chk("lat edge3 bus_addr", 32'(bus_addr), 32'(BASE));
    data_ready = 1'b0;
    tick; chk("bus_start one cycle", 32'(bus_start), 32'd0);
    wait_done("nominal", fd0);
    check_burst("nominal", w0, a0, fd0, 1'b0, 8'h00, 8'h00);
    chk("nominal overrun", 32'(overrun), 32'd0);

    // table-driven bursts
    for (int i = 0; i < 7; i++) begin
      bus_lat     = vecs[i].lat;
      ready_rand  = vecs[i].rnd_ready;
      ready_force = 1'b1;
      run_burst($sformatf("vec%0d", i), vecs[i].has_err, vecs[i].erra, vecs[i].ofs, w0, fd0);
      chk($sformatf("vec%0d tbl_words", i), 32'(wlog.size() - w0), 32'(vecs[i].exp_words));
      chk($sformatf("vec%0d tbl_fd", i),    32'(fd_cnt - fd0),     32'(vecs[i].exp_fd));
      chk($sformatf("vec%0d tbl_code", i),  32'(err_code),         32'(vecs[i].exp_code));
    end

    // backpressure: 50-cycle stall on word 2
    bus_lat = 10; ready_rand = 1'b0; ready_force = 1'b0;
    err_en = 1'b0; data_ofs = 8'h00;
    w0 = wlog.size(); a0 = alog.size(); fd0 = fd_cnt;
    pulse_dr;
    for (int w = 0; w < NW; w++) begin
      wait_valid($sformatf("bp word%0d", w));
      if (w == 2) begin
        bad_v = 0; bad_d = 0; starts = 0;
        chk("bp stall idx", 32'(out_idx), 32'd2);
        for (int c = 0; c < 50; c++) begin
          tick;
          if (out_valid !== 1'b1) bad_v++;
          if (out_data !== 16'h0506) bad_d++;
          if (bus_start !== 1'b0) starts++;
        end
        chk("bp valid drops", 32'(bad_v), 32'd0);
        chk("bp data changes", 32'(bad_d), 32'd0);
        chk("bp bus_start in stall", 32'(starts), 32'd0);
      end
      ready_force = 1'b1;
      tick;
      ready_force = 1'b0;
    end
    wait_done("bp", fd0);
    check_burst("bp", w0, a0, fd0, 1'b0, 8'h00, 8'h00);
    ready_force = 1'b1;

    // overrun: second edge while word 3 is in flight
    bus_lat = 10; ready_rand = 1'b0;
    w0 = wlog.size(); a0 = alog.size(); fd0 = fd_cnt;
    pulse_dr;
    k = 0;
    while (wlog.size() - w0 < 3 && k < 1000) begin tick; k++; end
    if (k >= 1000) bound_fail("ovr wait word3");
    pulse_dr;
    chk("ovr set", 32'(overrun), 32'd1);
    wait_done("ovr", fd0);
    check_burst("ovr", w0, a0, fd0, 1'b0, 8'h00, 8'h00);
    chk("ovr sticky", 32'(overrun), 32'd1);
    w0 = wlog.size(); a0 = alog.size(); fd0 = fd_cnt;
    pulse_dr;
    chk("ovr cleared on start", 32'(overrun), 32'd0);
    wait_done("ovr next", fd0);
    check_burst("ovr next", w0, a0, fd0, 1'b0, 8'h00, 8'h00);

    // timeout: bus never answers
    bus_mute = 1'b1;
    data_ready = 1'b1;
    tick; tick; tick;
    chk("tmo bus_start", 32'(bus_start), 32'd1);
    data_ready = 1'b0;
    k = 0;
    while (err !== 1'b1 && k < 300) begin tick; k++; end
    chk("tmo cycles after bus_start", 32'(k), 32'(T_CYC));
    chk("tmo err_code", 32'(err_code), 32'd2);
    chk("tmo out_valid", 32'(out_valid), 32'd0);
    repeat (5) tick;
    bus_mute = 1'b0;
    run_burst("after tmo", 1'b0, 8'h00, 8'h07, w0, fd0);

    // en dropped during EMIT
    bus_lat = 4; ready_rand = 1'b0; ready_force = 1'b0;
    err_en = 1'b0;
    fd0 = fd_cnt;
    pulse_dr;
    wait_valid("endrop");
    en = 1'b0;
    tick;
    chk("endrop out_valid", 32'(out_valid), 32'd0);
    a1 = alog.size();
    repeat (20) tick;
    chk("endrop no bus_start", 32'(alog.size() - a1), 32'd0);
    chk("endrop frame_done", 32'(fd_cnt - fd0), 32'd0);
    chk("endrop err", 32'(err), 32'd0);
    ready_force = 1'b1;
    pulse_dr;
    repeat (20) tick;
    chk("en0 edge ignored", 32'(alog.size() - a1), 32'd0);
    en = 1'b1;
    run_burst("after endrop", 1'b0, 8'h00, 8'h00, w0, fd0);

    // asynchronous reset mid-WAIT
    bus_lat = 10;
    pulse_dr;
    pulse_dr;
    chk("rst pre overrun", 32'(overrun), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_vals("async rst");
    tick; tick;
    rst = 1'b1;
    tick;
    run_burst("after rst", 1'b0, 8'h00, 8'h33, w0, fd0);

    // randomized bursts against the model
    for (int r = 0; r < 20; r++) begin
      bus_lat    = int'($urandom_range(1, 12));
      ready_rand = 1'b1;
      he         = ($urandom_range(0, 3) == 0);
      ea         = BASE + 8'($urandom_range(0, 2 * NW - 1));
      run_burst($sformatf("rnd%0d", r), he, ea, 8'($urandom), w0, fd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
